// File: rtl/score_row_normalize.sv
// Row-wise max subtraction and rounded, saturating requantization of a score matrix.
// One element per cycle: a MAX pass then a NORM pass for each row, START/DONE handshake.
module score_row_normalize #(
    parameter int N     = 3,
    parameter int D     = 3,
    parameter int WIN   = 16,
    parameter int WOUT  = 8,
    parameter int SHIFT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   START,
    input  logic signed [WIN-1:0]  c [N][D],
    output logic signed [WOUT-1:0] q [N][D],
    output logic                   BUSY,
    output logic                   DONE
);

    localparam int RW  = (N > 1) ? $clog2(N) : 1;
    localparam int KW  = (D > 1) ? $clog2(D) : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [WIN+1:0] RND    = (SHIFT > 0) ? ((WIN+2)'(1) << RSH) : '0;
    localparam logic signed [WIN+1:0] SAT_HI = (WIN+2)'((2 ** (WOUT - 1)) - 1);
    localparam logic signed [WIN+1:0] SAT_LO = (WIN+2)'(-(2 ** (WOUT - 1)));

    typedef enum logic [1:0] {
        IDLE,
        MAX,
        NORM
    } state_t;

    state_t                  state;
    logic signed [WIN-1:0]   snap [N][D];
    logic signed [WIN-1:0]   rowmax;
    logic [RW-1:0]           r;
    logic [KW-1:0]           k;

    logic signed [WIN-1:0]   elem;
    logic signed [WIN:0]     diff;
    logic signed [WIN+1:0]   rounded;
    logic signed [WIN+1:0]   scaled;
    logic signed [WOUT-1:0]  sat;

    // diff needs WIN+1 bits (range -(2^WIN-1)..0); the rounding add gets one more
    always_comb begin
        elem    = snap[r][k];
        diff    = {elem[WIN-1], elem} - {rowmax[WIN-1], rowmax};
        rounded = {diff[WIN], diff} + RND;
        scaled  = rounded >>> SHIFT;
        if (scaled > SAT_HI) begin
            sat = SAT_HI[WOUT-1:0];
        end else if (scaled < SAT_LO) begin
            sat = SAT_LO[WOUT-1:0];
        end else begin
            sat = scaled[WOUT-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            r      <= '0;
            k      <= '0;
            rowmax <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < D; j++) begin
                    snap[i][j] <= '0;
                    q[i][j]    <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            for (int unsigned j = 0; j < D; j++) begin
                                snap[i][j] <= c[i][j];
                            end
                        end
                        r     <= '0;
                        k     <= '0;
                        BUSY  <= 1'b1;
                        state <= MAX;
                    end
                end
                MAX: begin
                    if (k == '0) begin
                        rowmax <= elem;
                    end else if (elem > rowmax) begin
                        rowmax <= elem;
                    end
                    if (k == KW'(D - 1)) begin
                        k     <= '0;
                        state <= NORM;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                NORM: begin
                    q[r][k] <= sat;
                    if (k == KW'(D - 1)) begin
                        k <= '0;
                        if (r == RW'(N - 1)) begin
                            r     <= '0;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            r     <= r + 1'b1;
                            state <= MAX;
                        end
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_row_normalize.sv
// Scoreboard bench for score_row_normalize: three instances (main, SHIFT=0, 4x5 randomized).
module tb_score_row_normalize;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic              start_a, busy_a, done_a;
    logic signed [15:0] c_a [3][3];
    logic signed [7:0]  q_a [3][3];

    logic              start_b, busy_b, done_b;
    logic signed [15:0] c_b [3][3];
    logic signed [7:0]  q_b [3][3];

    logic              start_r, busy_r, done_r;
    logic signed [15:0] c_r [4][5];
    logic signed [7:0]  q_r [4][5];

    int exp_a[$];
    int exp_b[$];
    int exp_r[$];

    score_row_normalize #(.N(3), .D(3), .WIN(16), .WOUT(8), .SHIFT(2)) dut_a (
        .clk(clk), .reset(reset), .START(start_a), .c(c_a), .q(q_a), .BUSY(busy_a), .DONE(done_a));

    score_row_normalize #(.N(3), .D(3), .WIN(16), .WOUT(8), .SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .START(start_b), .c(c_b), .q(q_b), .BUSY(busy_b), .DONE(done_b));

    score_row_normalize #(.N(4), .D(5), .WIN(16), .WOUT(8), .SHIFT(3)) dut_r (
        .clk(clk), .reset(reset), .START(start_r), .c(c_r), .q(q_r), .BUSY(busy_r), .DONE(done_r));

    // Reference: subtract row max, round half up, floor-shift, clamp to 8 bits
    function automatic int ref_q(input int e, input int m, input int s);
        int d;
        int v;
        d = e - m;
        if (s > 0) v = (d + (1 << (s - 1))) >>> s;
        else       v = d;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    task automatic push_a();
        for (int i = 0; i < 3; i++) begin
            int m;
            m = c_a[i][0];
            for (int j = 1; j < 3; j++) if (c_a[i][j] > m) m = c_a[i][j];
            for (int j = 0; j < 3; j++) exp_a.push_back(ref_q(c_a[i][j], m, 2));
        end
    endtask

    task automatic push_r();
        for (int i = 0; i < 4; i++) begin
            int m;
            m = c_r[i][0];
            for (int j = 1; j < 5; j++) if (c_r[i][j] > m) m = c_r[i][j];
            for (int j = 0; j < 5; j++) exp_r.push_back(ref_q(c_r[i][j], m, 3));
        end
    endtask

    task automatic rand_a();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) c_a[i][j] = 16'($urandom);
    endtask

    // One-cycle START pulse; returns #1 after the sampling edge t0
    task automatic pulse(input int which);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_r = 1'b1;
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_r = 1'b0;
    endtask

    // Edges counted from now until DONE is seen; -1 if the budget expires
    task automatic wait_done(input int which, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && done_a) || (which == 1 && done_b) || (which == 2 && done_r)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy_a, done_a);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (q_a[i][j] !== 8'sd0) begin
                    errors++;
                    $display("FAIL reset_q[%0d][%0d]: got %0d expected 0", i, j, q_a[i][j]);
                end
            end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_main();
        int lit[9] = '{0, -15, -128, 0, 0, 0, -128, -128, 0};
        int n;
        c_a = '{'{16'sd100, 16'sd40, -16'sd500},
                '{16'sd7, 16'sd7, 16'sd7},
                '{-16'sd32768, -16'sd32768, 16'sd32767}};
        for (int i = 0; i < 9; i++) exp_a.push_back(lit[i]);
        pulse(0);
        wait_done(0, 40, n);
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL main_latency: got %0d edges expected 18", n);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL main_busy_at_done: got %b expected 0", busy_a);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL main_done_width: got %b expected 0", done_a);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int e;
                e = exp_a.pop_front();
                checks++;
                if ($signed(q_a[i][j]) !== e) begin
                    errors++;
                    $display("FAIL main_q[%0d][%0d]: got %0d expected %0d", i, j, q_a[i][j], e);
                end
            end
    endtask

    task automatic test_rounding();
        int lit_a[9] = '{0, 0, -1, 0, 0, 0, 0, 0, 0};
        int lit_b[9] = '{0, -105, -128, -2, -1, 0, 0, 0, 0};
        int n;
        c_a = '{'{16'sd10, 16'sd8, 16'sd4}, '{16'sd0, 16'sd0, 16'sd0}, '{16'sd0, 16'sd0, 16'sd0}};
        c_b = '{'{16'sd5, -16'sd100, -16'sd200}, '{16'sd1, 16'sd2, 16'sd3}, '{16'sd0, 16'sd0, 16'sd0}};
        for (int i = 0; i < 9; i++) begin
            exp_a.push_back(lit_a[i]);
            exp_b.push_back(lit_b[i]);
        end
        pulse(0);
        wait_done(0, 40, n);
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL round_latency: got %0d edges expected 18", n);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int e;
                e = exp_a.pop_front();
                checks++;
                if ($signed(q_a[i][j]) !== e) begin
                    errors++;
                    $display("FAIL round_q[%0d][%0d]: got %0d expected %0d", i, j, q_a[i][j], e);
                end
            end
        pulse(1);
        wait_done(1, 40, n);
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL shift0_latency: got %0d edges expected 18", n);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int e;
                e = exp_b.pop_front();
                checks++;
                if ($signed(q_b[i][j]) !== e) begin
                    errors++;
                    $display("FAIL shift0_q[%0d][%0d]: got %0d expected %0d", i, j, q_b[i][j], e);
                end
            end
        @(posedge clk);
        #1;
    endtask

    task automatic test_snapshot();
        int cnt = 0;
        int first = -1;
        rand_a();
        push_a();
        pulse(0);
        rand_a();
        for (int i = 1; i <= 40; i++) begin
            start_a = (i == 5 || i == 10);
            @(posedge clk);
            #1;
            if (done_a) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        start_a = 1'b0;
        checks++;
        if (cnt !== 1 || first !== 18) begin
            errors++;
            $display("FAIL snapshot_done: got %0d pulses first at %0d expected 1 at 18", cnt, first);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int e;
                e = exp_a.pop_front();
                checks++;
                if ($signed(q_a[i][j]) !== e) begin
                    errors++;
                    $display("FAIL snapshot_q[%0d][%0d]: got %0d expected %0d", i, j, q_a[i][j], e);
                end
            end
    endtask

    task automatic test_reset_mid();
        int n;
        c_a = '{'{16'sd100, 16'sd40, -16'sd500},
                '{16'sd7, 16'sd7, 16'sd7},
                '{-16'sd32768, -16'sd32768, 16'sd32767}};
        pulse(0);
        for (int i = 0; i < 6; i++) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: busy=%b done=%b expected 0 0", busy_a, done_a);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (q_a[i][j] !== 8'sd0) begin
                    errors++;
                    $display("FAIL midreset_q[%0d][%0d]: got %0d expected 0", i, j, q_a[i][j]);
                end
            end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_a();
        pulse(0);
        wait_done(0, 40, n);
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL midreset_latency: got %0d edges expected 18", n);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int e;
                e = exp_a.pop_front();
                checks++;
                if ($signed(q_a[i][j]) !== e) begin
                    errors++;
                    $display("FAIL midreset_q_after[%0d][%0d]: got %0d expected %0d", i, j, q_a[i][j], e);
                end
            end
    endtask

    task automatic test_back_to_back();
        int n;
        rand_a();
        push_a();
        start_a = 1'b1;
        @(posedge clk);
        #1;
        for (int run = 0; run < 3; run++) begin
            wait_done(0, 40, n);
            checks++;
            if (n !== ((run == 0) ? 18 : 19)) begin
                errors++;
                $display("FAIL b2b_spacing run %0d: got %0d edges expected %0d", run, n, (run == 0) ? 18 : 19);
            end
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    int e;
                    e = exp_a.pop_front();
                    checks++;
                    if ($signed(q_a[i][j]) !== e) begin
                        errors++;
                        $display("FAIL b2b_q run %0d [%0d][%0d]: got %0d expected %0d", run, i, j, q_a[i][j], e);
                    end
                end
            if (run < 2) begin
                rand_a();
                push_a();
            end else begin
                start_a = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int m = 0; m < 200; m++) begin
            int n;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 5; j++) begin
                    int v;
                    if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 8)) - 4;
                    else                           v = int'($urandom);
                    c_r[i][j] = 16'(v);
                end
            push_r();
            pulse(2);
            n = -1;
            for (int t = 1; t <= 60; t++) begin
                @(posedge clk);
                #1;
                checks++;
                if (busy_r && done_r) begin
                    errors++;
                    $display("FAIL rand_busy_done matrix %0d: busy=%b done=%b expected not both", m, busy_r, done_r);
                end
                if (done_r) begin
                    n = t;
                    break;
                end
            end
            checks++;
            if (n !== 40) begin
                errors++;
                $display("FAIL rand_latency matrix %0d: got %0d edges expected 40", m, n);
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 5; j++) begin
                    int e;
                    e = exp_r.pop_front();
                    checks++;
                    if ($signed(q_r[i][j]) !== e) begin
                        errors++;
                        $display("FAIL rand_q matrix %0d [%0d][%0d]: got %0d expected %0d", m, i, j, q_r[i][j], e);
                    end
                end
        end
    endtask

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_r = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                c_a[i][j] = '0;
                c_b[i][j] = '0;
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 5; j++) c_r[i][j] = '0;
        #1;
        reset = 1'b1;
        test_reset();
        test_main();
        test_rounding();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_row_normalize.md
Name: score_row_normalize

Overview:
- Downstream stage of the attention matrix-multiply block. Consumes its full-width signed result matrix (e.g. Q·K^T scores) and produces a narrow signed matrix ready for the softmax lookup / next multiply.
- For each row it finds the row maximum, subtracts it from every element, then arithmetic-shifts with rounding and saturates to WOUT bits.
- Processing is sequential: one element per cycle, with a START/DONE handshake that matches the multiplier's.

Parameters:
- N, 3, rows (sentence length)
- D, 3, columns per row
- WIN, 16, input element width (signed), equals WIDTHA+WIDTHB of the upstream multiplier
- WOUT, 8, output element width (signed)
- SHIFT, 2, right-shift amount applied after max subtraction (0..WIN)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- START  input  1  begin a run; sampled only in IDLE
- c  input  signed [WIN-1:0] x [N][D]  score matrix from upstream multiplier
- q  output  signed [WOUT-1:0] x [N][D]  normalized, requantized matrix (registered)
- BUSY  output  1  high while a run is in progress
- DONE  output  1  one-cycle pulse; q complete and valid

Behaviour:
- Reset (async, any time, including mid-run):
  - q all 0, BUSY=0, DONE=0, state IDLE.
  - Row/column counters, running max and captured snapshot are cleared.
  - A partially written q is discarded.
- States are IDLE, MAX, NORM.
- IDLE:
  - DONE=0.
  - START=1 at an edge: snapshot all of c into an internal register, r=0, k=0, BUSY<=1, go to MAX.
  - c is not sampled again during the run. Upstream may change c freely after the START edge.
- MAX:
  - Each edge consumes element [r][k] of the snapshot.
  - k=0 loads rowmax with the element. k>0 sets rowmax <= max(rowmax, element), using a signed compare.
  - After k=D-1: k=0, go to NORM.
- NORM:
  - Each edge computes diff = elem - rowmax in WIN+1 bits, signed. diff is always <= 0.
  - If SHIFT>0, add 2^(SHIFT-1), then arithmetic shift right by SHIFT (round half toward +inf). If SHIFT=0, no shift.
  - Saturate to [-(2^(WOUT-1)), 2^(WOUT-1)-1] and write q[r][k].
  - After k=D-1:
    - If r<N-1: r++, k=0, go to MAX.
    - Else: DONE<=1, BUSY<=0, go to IDLE.
- Latency: START sampled at edge t0. Last q write and DONE rise at edge t0+2·N·D. DONE is high for exactly one cycle and cleared at the next edge.
- q update order:
  - q rows are overwritten in order r=0..N-1 during the run and are not atomic.
  - Consumers read q only on DONE.
  - q holds its value between runs.
- START while BUSY=1 is ignored, with no queueing.
- START held high continuously: a new run starts in the IDLE cycle following DONE, i.e. back-to-back runs with one idle edge between them.
- Row of all-equal values: every output is 0.
- Extreme inputs: diff spans -(2^WIN - 1) to 0, and the WIN+1 intermediate width must not overflow.
- Rounding add: performed at WIN+2 bits so there is no wrap.

Test Plan:
1. N=3,D=3,WIN=16,WOUT=8,SHIFT=2. Row0=[100,40,-500] -> q row0=[0,-15,-128] (-500 saturates).
   Row1=[7,7,7] -> [0,0,0]. Row2=[-32768,-32768,32767] -> [-128,-128,0].
   DONE rises exactly 18 edges after the START edge, high for 1 cycle.
2. Rounding check, SHIFT=2. Row=[10,8,4] -> diffs [0,-2,-6] -> [0,0,-1] ((-2+2)>>>2=0, (-6+2)>>>2=-1).
   SHIFT=0 with row=[5,-100,-200] -> [0,-105,-128].
3. Snapshot check: change c the cycle after START -> q reflects the original c. START pulses during BUSY -> ignored, exactly one DONE pulse.
4. Assert reset midway (edge t0+7) -> q=0, BUSY=0, DONE=0 immediately (async). A new START then gives a correct result and DONE after 18 edges.
5. START held high for 3 runs with a changing c -> DONE pulses spaced 19 edges apart, each q matching its snapshot.
6. Randomized compare against a reference model for 200 matrices at N=4,D=5,SHIFT=3. BUSY is never high in the same cycle as DONE.
